// File: rtl/hash_lookup.sv
// hash_lookup: drives the hash unit for one 64-bit key, reads the indexed match-table entry
// and returns hit/miss plus action. Define HASH_LOOKUP_TIMEOUT_EN to bound the hash wait.
module hash_lookup #(
    parameter int INDEX_WIDTH  = 8,
    parameter int ACTION_WIDTH = 32,
    parameter int TIMEOUT      = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    input  logic [63:0]             req_key_i,
    output logic                    req_ready_o,
    output logic                    hash_start_o,
    output logic [63:0]             hash_key_o,
    input  logic                    hash_ready_i,
    input  logic [31:0]             hash_val_i,
    output logic                    mem_rd_o,
    output logic [INDEX_WIDTH-1:0]  mem_addr_o,
    input  logic                    mem_valid_i,
    input  logic [63:0]             mem_key_i,
    input  logic [ACTION_WIDTH-1:0] mem_action_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic                    resp_hit_o,
    output logic                    resp_err_o,
    output logic [ACTION_WIDTH-1:0] resp_action_o,
    output logic                    busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        HASH,
        READ,
        CMP,
        RESP
    } state_t;

    state_t                 state;
    logic [63:0]            key_q;
    logic [INDEX_WIDTH-1:0] idx_q;
    logic                   key_match;
    logic                   hash_val_unused;

    // Hash bits above the table index are intentionally dropped; collisions miss on key compare.
    assign hash_val_unused = ^hash_val_i[31:INDEX_WIDTH];

    assign key_match  = mem_valid_i && (mem_key_i == key_q);
    assign hash_key_o = key_q;
    assign mem_addr_o = idx_q;

`ifdef HASH_LOOKUP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt;
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT;

    assign resp_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            key_q         <= '0;
            idx_q         <= '0;
            req_ready_o   <= 1'b1;
            hash_start_o  <= 1'b0;
            mem_rd_o      <= 1'b0;
            resp_valid_o  <= 1'b0;
            resp_hit_o    <= 1'b0;
            resp_action_o <= '0;
            busy_o        <= 1'b0;
`ifdef HASH_LOOKUP_TIMEOUT_EN
            wait_cnt      <= '0;
            resp_err_o    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        key_q        <= req_key_i;
                        req_ready_o  <= 1'b0;
                        hash_start_o <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= HASH;
`ifdef HASH_LOOKUP_TIMEOUT_EN
                        wait_cnt     <= '0;
`endif
                    end
                end

                // A hash result arriving on the limit cycle takes priority over the timeout.
                HASH: begin
                    if (hash_ready_i) begin
                        idx_q        <= hash_val_i[INDEX_WIDTH-1:0];
                        hash_start_o <= 1'b0;
                        mem_rd_o     <= 1'b1;
                        state        <= READ;
                    end
`ifdef HASH_LOOKUP_TIMEOUT_EN
                    else if (wait_cnt == TIMEOUT_CNT) begin
                        hash_start_o  <= 1'b0;
                        resp_valid_o  <= 1'b1;
                        resp_hit_o    <= 1'b0;
                        resp_action_o <= '0;
                        resp_err_o    <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end

                READ: begin
                    mem_rd_o <= 1'b0;
                    state    <= CMP;
                end

                // Table data returned for the READ strobe is only valid in this cycle.
                CMP: begin
                    resp_valid_o  <= 1'b1;
                    resp_hit_o    <= key_match;
                    resp_action_o <= key_match ? mem_action_i : '0;
`ifdef HASH_LOOKUP_TIMEOUT_EN
                    resp_err_o    <= 1'b0;
`endif
                    state         <= RESP;
                end

                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o  <= 1'b0;
                        resp_hit_o    <= 1'b0;
                        resp_action_o <= '0;
`ifdef HASH_LOOKUP_TIMEOUT_EN
                        resp_err_o    <= 1'b0;
`endif
                        req_ready_o   <= 1'b1;
                        busy_o        <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state        <= IDLE;
                    req_ready_o  <= 1'b1;
                    hash_start_o <= 1'b0;
                    mem_rd_o     <= 1'b0;
                    resp_valid_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_lookup.sv
// Table-driven bench for hash_lookup: directed lookups with a bench-side hash and RAM model,
// plus hand sequences for spurious ready, hash timeout/stall and reset mid-operation.
module tb_hash_lookup;

    localparam int INDEX_WIDTH  = 8;
    localparam int ACTION_WIDTH = 32;
    localparam int TIMEOUT      = 64;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    req_valid_i = 1'b0;
    logic [63:0]             req_key_i = '0;
    logic                    req_ready_o;
    logic                    hash_start_o;
    logic [63:0]             hash_key_o;
    logic                    hash_ready_i = 1'b0;
    logic [31:0]             hash_val_i = '0;
    logic                    mem_rd_o;
    logic [INDEX_WIDTH-1:0]  mem_addr_o;
    logic                    mem_valid_i = 1'b0;
    logic [63:0]             mem_key_i = '0;
    logic [ACTION_WIDTH-1:0] mem_action_i = '0;
    logic                    resp_valid_o;
    logic                    resp_ready_i = 1'b0;
    logic                    resp_hit_o;
    logic                    resp_err_o;
    logic [ACTION_WIDTH-1:0] resp_action_o;
    logic                    busy_o;

    int errors = 0;
    int checks = 0;

    // Current table entry returned by the RAM model; other cycles return a decoy that would hit.
    logic                    cur_valid = 1'b0;
    logic [63:0]             cur_mkey = '0;
    logic [63:0]             cur_key = '0;
    logic [ACTION_WIDTH-1:0] cur_act = '0;

    hash_lookup #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .ACTION_WIDTH(ACTION_WIDTH),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_key_i    (req_key_i),
        .req_ready_o  (req_ready_o),
        .hash_start_o (hash_start_o),
        .hash_key_o   (hash_key_o),
        .hash_ready_i (hash_ready_i),
        .hash_val_i   (hash_val_i),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_valid_i  (mem_valid_i),
        .mem_key_i    (mem_key_i),
        .mem_action_i (mem_action_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_hit_o   (resp_hit_o),
        .resp_err_o   (resp_err_o),
        .resp_action_o(resp_action_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_o) begin
            mem_valid_i  <= cur_valid;
            mem_key_i    <= cur_mkey;
            mem_action_i <= cur_act;
        end else begin
            mem_valid_i  <= 1'b1;
            mem_key_i    <= cur_key;
            mem_action_i <= 32'hbad0_bad0;
        end
    end

    typedef struct {
        logic [63:0]             key;
        int                      k;
        logic [31:0]             hval;
        logic                    mvalid;
        logic [63:0]             mkey;
        logic [ACTION_WIDTH-1:0] mact;
        int                      bp;
        logic [INDEX_WIDTH-1:0]  exp_addr;
        logic                    exp_hit;
        logic [ACTION_WIDTH-1:0] exp_act;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req_ready"}, req_ready_o, 1);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_hash_start"}, hash_start_o, 0);
        chk({tag, "_hash_key"}, hash_key_o, 0);
        chk({tag, "_mem_rd"}, mem_rd_o, 0);
        chk({tag, "_mem_addr"}, mem_addr_o, 0);
        chk({tag, "_resp_valid"}, resp_valid_o, 0);
        chk({tag, "_resp_hit"}, resp_hit_o, 0);
        chk({tag, "_resp_err"}, resp_err_o, 0);
        chk({tag, "_resp_action"}, resp_action_o, 0);
    endtask

    task automatic lookup(input vec_t v);
        int cyc;
        bit seen;
        logic                    h_hold;
        logic [ACTION_WIDTH-1:0] a_hold;
        cur_valid = v.mvalid;
        cur_mkey  = v.mkey;
        cur_act   = v.mact;
        cur_key   = v.key;
        @(negedge clk);
        chk("idle_req_ready", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_key_i   = v.key;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            req_valid_i = 1'b0;
            req_key_i   = 64'h0;
            if (resp_valid_o) begin
                seen = 1;
            end else begin
                if (cyc == 1) begin
                    chk("hash_busy", busy_o, 1);
                    chk("hash_req_ready", req_ready_o, 0);
                end
                if (cyc <= 1 + v.k) begin
                    chk("hash_start_held", hash_start_o, 1);
                    chk("hash_key", hash_key_o, v.key);
                end
                if (cyc == 2 + v.k) begin
                    chk("read_start_low", hash_start_o, 0);
                    chk("read_mem_rd", mem_rd_o, 1);
                    chk("read_mem_addr", mem_addr_o, v.exp_addr);
                end
                if (cyc == 3 + v.k) chk("cmp_mem_rd", mem_rd_o, 0);
                hash_ready_i = (cyc == 1 + v.k);
                hash_val_i   = hash_ready_i ? v.hval : 32'h5555_5500;
            end
        end
        hash_ready_i = 1'b0;
        chk("resp_seen", seen, 1);
        chk("resp_latency", cyc, 4 + v.k);
        chk("resp_hit", resp_hit_o, v.exp_hit);
        chk("resp_action", resp_action_o, v.exp_act);
        chk("resp_err", resp_err_o, 0);
        chk("resp_start_low", hash_start_o, 0);
        h_hold = resp_hit_o;
        a_hold = resp_action_o;
        for (int i = 0; i < v.bp; i++) begin
            @(negedge clk);
            chk("bp_valid", resp_valid_o, 1);
            chk("bp_hit_stable", resp_hit_o, h_hold);
            chk("bp_action_stable", resp_action_o, a_hold);
            chk("bp_req_ready", req_ready_o, 0);
        end
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        chk("post_resp_valid", resp_valid_o, 0);
        chk("post_req_ready", req_ready_o, 1);
        chk("post_busy", busy_o, 0);
    endtask

    initial begin
        int cyc;
        int nresp;
        vecs[0] = '{64'hdead_beef_abcd_ef00, 3, 32'h0000_1234, 1'b1, 64'hdead_beef_abcd_ef00,
                    32'hcafe_0001, 0, 8'h34, 1'b1, 32'hcafe_0001};
        vecs[1] = '{64'hdead_beef_abcd_ef00, 3, 32'h0000_1234, 1'b1, 64'hdead_beef_abcd_ef01,
                    32'hcafe_0001, 0, 8'h34, 1'b0, 32'h0};
        vecs[2] = '{64'hdead_beef_abcd_ef00, 3, 32'h0000_1234, 1'b0, 64'hdead_beef_abcd_ef00,
                    32'hcafe_0001, 0, 8'h34, 1'b0, 32'h0};
        vecs[3] = '{64'hdead_beef_abcd_ef00, 0, 32'h0000_1234, 1'b1, 64'hdead_beef_abcd_ef00,
                    32'hcafe_0001, 5, 8'h34, 1'b1, 32'hcafe_0001};
        vecs[4] = '{64'h1111_2222_3333_4444, 1, 32'hffff_ff34, 1'b1, 64'h1111_2222_3333_4444,
                    32'h5a5a_0005, 0, 8'h34, 1'b1, 32'h5a5a_0005};
        vecs[5] = '{64'h0123_4567_89ab_cdef, 2, 32'h0000_00a5, 1'b1, 64'h8123_4567_89ab_cdef,
                    32'h0000_0077, 1, 8'ha5, 1'b0, 32'h0};

        repeat (2) @(negedge clk);
        chk_reset_state("por");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                // Spurious hash_ready while idle must not disturb the FSM.
                @(negedge clk);
                hash_ready_i = 1'b1;
                hash_val_i   = 32'h0000_0099;
                @(negedge clk);
                hash_ready_i = 1'b0;
                chk("spur_busy", busy_o, 0);
                chk("spur_req_ready", req_ready_o, 1);
                chk("spur_hash_start", hash_start_o, 0);
                chk("spur_mem_rd", mem_rd_o, 0);
            end
            lookup(vecs[i]);
        end

        // Hash never answers.
        cur_key = 64'hfeed_0000_0000_0001;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_key_i   = 64'hfeed_0000_0000_0001;
        @(negedge clk);
        req_valid_i = 1'b0;
        cyc = 1;
`ifdef HASH_LOOKUP_TIMEOUT_EN
        while (!resp_valid_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("to_latency", cyc, TIMEOUT + 2);
        chk("to_valid", resp_valid_o, 1);
        chk("to_err", resp_err_o, 1);
        chk("to_hit", resp_hit_o, 0);
        chk("to_action", resp_action_o, 0);
        chk("to_start_low", hash_start_o, 0);
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        chk("to_post_req_ready", req_ready_o, 1);
        chk("to_post_err", resp_err_o, 0);
`else
        nresp = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (resp_valid_o) nresp++;
        end
        chk("stall_no_resp", nresp, 0);
        chk("stall_busy", busy_o, 1);
        chk("stall_hash_start", hash_start_o, 1);
        chk("stall_err", resp_err_o, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("stall_rst");
`endif

        // Reset while in HASH.
        @(negedge clk);
        req_valid_i = 1'b1;
        req_key_i   = 64'h0abc_0000_0000_0002;
        @(negedge clk);
        req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("hash_rst_pre_start", hash_start_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("hash_rst");

        // Reset while in RESP: no response may follow.
        @(negedge clk);
        req_valid_i = 1'b1;
        req_key_i   = 64'h0abc_0000_0000_0003;
        @(negedge clk);
        req_valid_i  = 1'b0;
        hash_ready_i = 1'b1;
        hash_val_i   = 32'h0000_0011;
        @(negedge clk);
        hash_ready_i = 1'b0;
        cyc = 0;
        while (!resp_valid_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("resp_rst_pre_valid", resp_valid_o, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("resp_rst");
        nresp = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid_o) nresp++;
        end
        chk("resp_rst_no_resp", nresp, 0);

        lookup(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
